address_decoder: RTL and testbench
==================================

Name: address_decoder

Overview:
- Synchronous 3-to-8 one-hot address decoder with a select/enable input.
- Used in the memory block to turn a 3-bit word address into one of eight row/word select lines.
- Outputs are registered: a decoded line appears one clock after the address and select are sampled.
- A one-hot "any line active" flag is provided for downstream use.

Parameters:
- ADDR_W, 3, address width in bits.
- N_OUT, 2**ADDR_W (8), number of select lines. Must equal 2**ADDR_W; no other value is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- select  input  1  decoder enable, active high.
- address  input  [0:ADDR_W-1]  word address. Bit 0 is the LSB: value = address[0]*1 + address[1]*2 + address[2]*4.
- S  output  [0:N_OUT-1]  one-hot select lines, active high. S[k] is line k.
- any_sel  output  1  high when exactly one S line is high (registered, same cycle as S).

Behaviour:
- Bit ordering is normative. Both vectors use ascending ranges. Index k = sum of address[i]*2^i.
  - address = 3'b100 (address[0]=1) selects S[1].
  - 3'b010 selects S[2]; 3'b110 selects S[3]; 3'b001 selects S[4]; 3'b111 selects S[7].
- Reset: while rst_n=0 at a rising clk edge, S <= all zeros and any_sel <= 0. Reset overrides select and address. No asynchronous path.
- Normal operation (rst_n=1), on each rising clk edge:
  - select=1: S <= one-hot with only bit k set; any_sel <= 1.
  - select=0: S <= all zeros; any_sel <= 0, regardless of address.
- Latency is exactly 1 clock from sampled inputs to S and any_sel. There is no combinational input-to-output path.
- Invariant: S is always all-zero or exactly one-hot. any_sel equals the OR of S.
- Address changes while select=1 move the active line on the next edge. There is no intermediate all-zero cycle and no two-hot cycle.
- select deasserting and the address changing on the same edge: the result is all zeros.
- Reset asserted mid-operation: S clears on that edge. After release, the first edge with select=1 decodes normally.
- X/Z handling: none required; inputs are assumed to be driven.

Decomposition:
- Shared package mem_pkg holds ADDR_W and N_OUT as localparams, plus a function onehot_decode(addr) returning an N_OUT-bit ascending vector.
- One natural sub-module, address_decode_core: purely combinational (address, select) -> one-hot vector.
- address_decoder instantiates the core and adds the output register, reset and any_sel logic.
- The verification side adds an assertion, "S is zero or one-hot; any_sel == |S", in a bind file.

Test Plan:
- Reset: rst_n=0 for 2 cycles with select=1, address=3'b111 -> S=8'b0, any_sel=0 during reset. First decode appears on the edge after rst_n=1.
- Sweep: select=1, address 000,100,010,110,001,101,011,111 on successive cycles -> one cycle later S[0],S[1],...,S[7] respectively is the only high bit; any_sel=1 throughout.
- Disable: select=0, address=3'b000 after the sweep -> next cycle S=all zeros, any_sel=0. Repeat with address=3'b101 -> still all zeros.
- Back-to-back change: address 3'b011 then 3'b100 on consecutive edges with select=1 -> S[6] for one cycle, then S[1]. Never two bits high, never an all-zero gap.
- Mid-operation reset: select=1, address=3'b110, S[3] high; assert rst_n=0 for one edge -> S=0 that cycle. Release -> S[3] again one cycle later.
- Random: 1000 cycles of random select/address with occasional resets -> matches the 1-cycle-delayed golden model; one-hot assertion never fires.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and the address-to-line decode function for the memory block.
// Vectors run ascending: index 0 of address is the LSB, S[k] is line k.
package mem_pkg;

    localparam int ADDR_W = 3;
    localparam int N_OUT  = 2 ** ADDR_W;

    typedef logic [0:ADDR_W-1] addr_t;
    typedef logic [0:N_OUT-1]  lines_t;

    // address[i] carries weight 2**i, so rebuild a plain binary index first.
    function automatic lines_t onehot_decode(input addr_t addr);
        logic [ADDR_W-1:0] idx;
        lines_t            res;
        for (int i = 0; i < ADDR_W; i++) begin
            idx[i] = addr[i];
        end
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/address_decoder_if.sv
// Decoder request/response bundle: address + select in, select lines + flag out.
interface address_decoder_if;
    import mem_pkg::*;

    logic   select;
    addr_t  address;
    lines_t S;
    logic   any_sel;

    modport master (output select, output address, input S, input any_sel);
    modport slave  (input select, input address, output S, output any_sel);

endinterface

// File: rtl/address_decoder_core.sv
// Combinational 3-to-8 decode with enable; all-zero when select is low.
module address_decode_core
    import mem_pkg::*;
(
    input  logic   select,
    input  addr_t  address,
    output lines_t lines
);

    assign lines = select ? onehot_decode(address) : '0;

endmodule

// File: rtl/address_decoder.sv
// Registered one-hot address decoder: one clock from (address, select) to S/any_sel.
module address_decoder
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    address_decoder_if.slave  bus
);

    lines_t dec;
    lines_t s_q;
    logic   any_q;

    address_decode_core u_core (
        .select  (bus.select),
        .address (bus.address),
        .lines   (dec)
    );

    // Both outputs load from the same decoded vector, so S and any_sel never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q   <= '0;
            any_q <= 1'b0;
        end else begin
            s_q   <= dec;
            any_q <= |dec;
        end
    end

    assign bus.S       = s_q;
    assign bus.any_sel = any_q;

endmodule

// File: tb/tb_address_decoder.sv
// Directed and random checks of address_decoder against hand-computed one-hot values.
module tb_address_decoder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    address_decoder_if bus ();

    address_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [0:N_OUT] got, input logic [0:N_OUT] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got S/any=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then compare S and any_sel.
    task automatic step(input string tag, input logic r, input logic sel,
                        input logic [0:ADDR_W-1] a, input logic [0:N_OUT-1] exp_s);
        rst_n       = r;
        bus.select  = sel;
        bus.address = a;
        @(posedge clk);
        #1;
        chk(tag, {bus.S, bus.any_sel}, {exp_s, |exp_s});
    endtask

    // Independent model: weight each address bit, then build the line with a shift.
    function automatic logic [0:N_OUT-1] model(input logic r, input logic sel, input logic [0:ADDR_W-1] a);
        int k;
        logic [N_OUT-1:0] desc;
        logic [0:N_OUT-1] asc;
        k = a[0] * 1 + a[1] * 2 + a[2] * 4;
        desc = (r && sel) ? (8'b1000_0000 >> k) : 8'b0;
        asc = desc;
        return asc;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            assert ($onehot0(bus.S) && (bus.any_sel == (|bus.S)))
                else $error("one-hot invariant violated: S=%b any_sel=%b", bus.S, bus.any_sel);
        end
    end

    initial begin
        logic r, sel;
        logic [0:ADDR_W-1] a;

        // Reset held for two edges with select=1, address=111.
        step("rst0", 1'b0, 1'b1, 3'b111, 8'b0000_0000);
        step("rst1", 1'b0, 1'b1, 3'b111, 8'b0000_0000);

        // Sweep: each address lights S[0]..S[7] in order.
        step("sw0", 1'b1, 1'b1, 3'b000, 8'b1000_0000);
        step("sw1", 1'b1, 1'b1, 3'b100, 8'b0100_0000);
        step("sw2", 1'b1, 1'b1, 3'b010, 8'b0010_0000);
        step("sw3", 1'b1, 1'b1, 3'b110, 8'b0001_0000);
        step("sw4", 1'b1, 1'b1, 3'b001, 8'b0000_1000);
        step("sw5", 1'b1, 1'b1, 3'b101, 8'b0000_0100);
        step("sw6", 1'b1, 1'b1, 3'b011, 8'b0000_0010);
        step("sw7", 1'b1, 1'b1, 3'b111, 8'b0000_0001);

        // Disable, including select drop with an address change on the same edge.
        step("dis0", 1'b1, 1'b0, 3'b000, 8'b0000_0000);
        step("dis5", 1'b1, 1'b0, 3'b101, 8'b0000_0000);

        // Back-to-back address change: S[6] then S[1], no gap.
        step("b2b6", 1'b1, 1'b1, 3'b011, 8'b0000_0010);
        step("b2b1", 1'b1, 1'b1, 3'b100, 8'b0100_0000);

        // Mid-operation reset.
        step("mid3", 1'b1, 1'b1, 3'b110, 8'b0001_0000);
        step("midr", 1'b0, 1'b1, 3'b110, 8'b0000_0000);
        step("mid3b", 1'b1, 1'b1, 3'b110, 8'b0001_0000);
        step("dropc", 1'b1, 1'b0, 3'b111, 8'b0000_0000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1000; i++) begin
            r   = ($urandom_range(0, 19) != 0);
            sel = ($urandom_range(0, 3) != 0);
            a   = 3'($urandom_range(0, 7));
            step("rand", r, sel, a, model(r, sel, a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
